// File: rtl/bram_int.sv
// Capture front end for one 32-bit BRAM port: stores valid samples into a wrapping ring
// and polls a processor-owned control word, rewinding the ring when that word is cleared.
module bram_int #(
  parameter logic [31:0] CTRL_ADDR = 32'h0000_0000,
  parameter logic [31:0] DATA_BASE = 32'h0000_0004,
  parameter int unsigned DEPTH     = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [31:0] datos,
  input  logic [31:0] dout,
  output logic        enable,
  output logic        we,
  output logic [31:0] din,
  output logic [31:0] addr
);

  // state | meaning
  // IDLE  | one cycle after reset, outputs held at reset values, inputs ignored
  // POLL  | last cycle presented a control-word read
  // WRITE | last cycle presented a sample write
  typedef enum logic [1:0] {IDLE, POLL, WRITE} state_t;

  localparam logic [31:0] LAST_ADDR = DATA_BASE + ((32'(DEPTH) - 32'd1) << 2);

  state_t      state;
  logic [31:0] wr_ptr;
  logic        rd_pend;
  logic        flag_prev;

  logic        flag;
  logic        rewind;
  logic [31:0] wr_base;
  logic [31:0] wr_next;

  // A cleared control word is only acted on when it was seen nonzero at the previous poll.
  always_comb begin
    flag    = |dout;
    rewind  = rd_pend & flag_prev & ~flag;
    wr_base = rewind ? DATA_BASE : wr_ptr;
    wr_next = (wr_base == LAST_ADDR) ? DATA_BASE : wr_base + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      enable    <= 1'b0;
      we        <= 1'b0;
      din       <= '0;
      addr      <= CTRL_ADDR;
      wr_ptr    <= DATA_BASE;
      rd_pend   <= 1'b0;
      flag_prev <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= POLL;
        end
        POLL, WRITE: begin
          if (rd_pend) flag_prev <= flag;
          enable <= 1'b1;
          if (valid) begin
            state   <= WRITE;
            we      <= 1'b1;
            addr    <= wr_base;
            din     <= datos;
            wr_ptr  <= wr_next;
            rd_pend <= 1'b0;
          end else begin
            state   <= POLL;
            we      <= 1'b0;
            addr    <= CTRL_ADDR;
            rd_pend <= 1'b1;
            if (rewind) wr_ptr <= DATA_BASE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_int.sv
// Randomized self-checking bench for bram_int: two instances (default ring and a 4-word ring)
// share stimulus and are compared against a ring-index model of the capture behaviour.
module tb_bram_int;

  localparam logic [31:0] CTRL = 32'h0000_0000;
  localparam logic [31:0] BASE = 32'h0000_0004;
  localparam int DEPTH_A = 1023;
  localparam int DEPTH_B = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] datos = '0;
  logic [31:0] dout = '0;

  logic        enable_a, we_a, enable_b, we_b;
  logic [31:0] din_a, addr_a, din_b, addr_b;
  logic [65:0] obs_a, obs_b;

  assign obs_a = {enable_a, we_a, addr_a, din_a};
  assign obs_b = {enable_b, we_b, addr_b, din_b};

  bram_int dut_a (
    .clk(clk), .rst_n(rst_n), .valid(valid), .datos(datos), .dout(dout),
    .enable(enable_a), .we(we_a), .din(din_a), .addr(addr_a)
  );

  bram_int #(.DEPTH(DEPTH_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid(valid), .datos(datos), .dout(dout),
    .enable(enable_b), .we(we_b), .din(din_b), .addr(addr_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: ring slot indices, last flag seen by processor polling, last written data
  int          ka, kb;
  logic        prev_flag;
  logic [31:0] last_din;
  logic [65:0] exp_a, exp_b;

  task automatic model_reset();
    ka = 0; kb = 0; prev_flag = 1'b0; last_din = '0;
  endtask

  // one clock: drive at negedge, predict, return at posedge+1
  task automatic step(input logic v, input logic [31:0] d);
    @(negedge clk);
    valid = v;
    datos = d;
    if (v) begin
      exp_a = {2'b11, BASE + 32'(4 * ka), d};
      exp_b = {2'b11, BASE + 32'(4 * kb), d};
      ka = (ka + 1) % DEPTH_A;
      kb = (kb + 1) % DEPTH_B;
      last_din = d;
    end else begin
      exp_a = {2'b10, CTRL, last_din};
      exp_b = exp_a;
    end
    @(posedge clk);
    #1;
  endtask

  // processor changes the control word; callers give it time to be polled
  task automatic set_dout(input logic [31:0] v);
    dout = v;
    if (prev_flag && (v == 32'd0)) begin
      ka = 0; kb = 0;
    end
    prev_flag = (v != 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b0; dout = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b0; dout = '0;
    model_reset();
    #1;
    checks++;
    if (obs_a !== {2'b00, CTRL, 32'd0}) begin
      errors++; $display("FAIL reset_hold obs=%h exp=%h", obs_a, {2'b00, CTRL, 32'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs_b !== {2'b00, CTRL, 32'd0}) begin
      errors++; $display("FAIL reset_idle obs=%h exp=%h", obs_b, {2'b00, CTRL, 32'd0});
    end
    @(posedge clk); #1;
    checks++;
    if (obs_a !== {2'b10, CTRL, 32'd0}) begin
      errors++; $display("FAIL reset_first_poll obs=%h exp=%h", obs_a, {2'b10, CTRL, 32'd0});
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'd0);
      checks += 2;
      if (obs_a !== exp_a || obs_b !== exp_b) begin
        errors++; $display("FAIL reset_poll obs=%h/%h exp=%h", obs_a, obs_b, exp_a);
      end
    end
  endtask

  task automatic test_single_writes();
    logic [31:0] data [3];
    data[0] = 32'hA5A5_0001; data[1] = 32'h5A5A_0002; data[2] = 32'hC0DE_0003;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, data[i]);
      checks++;
      if (obs_a !== {2'b11, 32'(4 + 4 * i), data[i]}) begin
        errors++; $display("FAIL single_write obs=%h exp=%h", obs_a, {2'b11, 32'(4 + 4 * i), data[i]});
      end
      step(1'b0, $urandom);
      checks++;
      if (obs_a !== exp_a) begin
        errors++; $display("FAIL single_we_drop obs=%h exp=%h", obs_a, exp_a);
      end
    end
  endtask

  task automatic test_flag();
    step(1'b1, $urandom);
    checks++;
    if (addr_a !== 32'd16) begin
      errors++; $display("FAIL fourth_write addr=%h exp=%h", addr_a, 32'd16);
    end
    set_dout(32'd1);
    repeat (3) step(1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, $urandom);
      checks += 2;
      if (obs_a !== exp_a || addr_a !== 32'(20 + 4 * i)) begin
        errors++; $display("FAIL no_rewind obs=%h exp=%h", obs_a, exp_a);
      end
      if (obs_b !== exp_b) begin
        errors++; $display("FAIL no_rewind_small obs=%h exp=%h", obs_b, exp_b);
      end
      step(1'b0, 32'd0);
    end
    set_dout(32'd0);
    repeat (3) step(1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, $urandom);
      checks += 2;
      if (obs_a !== exp_a || addr_a !== 32'(4 + 4 * i)) begin
        errors++; $display("FAIL rewind obs=%h exp=%h", obs_a, exp_a);
      end
      if (obs_b !== exp_b) begin
        errors++; $display("FAIL rewind_small obs=%h exp=%h", obs_b, exp_b);
      end
      step(1'b0, 32'd0);
    end
  endtask

  task automatic test_rewind_with_valid();
    set_dout(32'hDEAD_0000);
    repeat (3) step(1'b0, 32'd0);
    for (int i = 0; i < 2; i++) step(1'b1, $urandom);
    step(1'b0, 32'd0);
    step(1'b0, 32'd0);
    set_dout(32'd0);
    step(1'b1, 32'h1234_5678);
    checks++;
    if (obs_a !== {2'b11, BASE, 32'h1234_5678}) begin
      errors++; $display("FAIL rewind_same_cycle obs=%h exp=%h", obs_a, {2'b11, BASE, 32'h1234_5678});
    end
    step(1'b1, 32'h8765_4321);
    checks++;
    if (obs_a !== {2'b11, BASE + 32'd4, 32'h8765_4321}) begin
      errors++; $display("FAIL rewind_then_next obs=%h exp=%h", obs_a, {2'b11, BASE + 32'd4, 32'h8765_4321});
    end
    step(1'b0, 32'd0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, $urandom);
      checks++;
      if (obs_a !== exp_a || addr_a !== 32'(4 + 4 * i)) begin
        errors++; $display("FAIL b2b obs=%h exp=%h", obs_a, exp_a);
      end
    end
    step(1'b0, 32'd0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, $urandom);
      checks++;
      if (obs_b !== exp_b) begin
        errors++; $display("FAIL wrap_small obs=%h exp=%h", obs_b, exp_b);
      end
    end
    checks++;
    if (addr_b !== BASE) begin
      errors++; $display("FAIL wrap_fifth addr=%h exp=%h", addr_b, BASE);
    end
    step(1'b0, 32'd0);
  endtask

  task automatic test_reset_mid();
    step(1'b1, 32'hFACE_B00C);
    step(1'b1, 32'hFACE_B00D);
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    checks += 2;
    if (obs_a !== {2'b00, CTRL, 32'd0}) begin
      errors++; $display("FAIL reset_mid obs=%h exp=%h", obs_a, {2'b00, CTRL, 32'd0});
    end
    if (obs_b !== {2'b00, CTRL, 32'd0}) begin
      errors++; $display("FAIL reset_mid_small obs=%h exp=%h", obs_b, {2'b00, CTRL, 32'd0});
    end
    dout = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step(1'b1, 32'h0BAD_F00D);
    checks++;
    if (obs_a !== {2'b11, BASE, 32'h0BAD_F00D}) begin
      errors++; $display("FAIL reset_mid_restart obs=%h exp=%h", obs_a, {2'b11, BASE, 32'h0BAD_F00D});
    end
    step(1'b0, 32'd0);
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 200; it++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        for (int j = 0; j < int'($urandom_range(1, 5)); j++) begin
          step(1'b1, $urandom);
          checks += 2;
          if (obs_a !== exp_a || obs_b !== exp_b) begin
            errors++; $display("FAIL rand_write obs=%h/%h exp=%h/%h", obs_a, obs_b, exp_a, exp_b);
          end
        end
      end else if (kind < 8) begin
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
          step(1'b0, $urandom);
          checks += 2;
          if (obs_a !== exp_a || obs_b !== exp_b) begin
            errors++; $display("FAIL rand_idle obs=%h/%h exp=%h/%h", obs_a, obs_b, exp_a, exp_b);
          end
        end
      end else begin
        set_dout(($urandom_range(0, 1) == 1) ? $urandom : 32'd0);
        repeat (2) step(1'b0, 32'd0);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_writes();
    test_flag();
    test_rewind_with_valid();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
